writeback_arbiter: RTL and testbench

//  Write-side driver of the register file: owns its single write port (write_back_en/_reg/write_back).

---
 rtl/mips_pkg.sv | 13 +
 rtl/writeback_arbiter_if.sv | 47 ++++
 rtl/writeback_arbiter_fifo.sv | 45 ++++
 rtl/writeback_arbiter.sv | 105 ++++++++++
 tb/tb_writeback_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared register-file widths and the write-back entry type used by the
// write-side arbiter and its LSU result FIFO.
package mips_pkg;
   localparam int REG_W    = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;
   localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [REG_W-1:0]  dst_reg;
      logic [DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// Pipeline-side bundle of the write-back arbiter: ALU/LSU result inputs,
// long-latency issue marks, hazard queries and the register-file write port.
interface writeback_arbiter_if;
   import mips_pkg::*;

   logic              alu_valid;
   logic [REG_W-1:0]  alu_reg;
   logic [DATA_W-1:0] alu_data;

   logic              lsu_valid;
   logic              lsu_ready;
   logic [REG_W-1:0]  lsu_reg;
   logic [DATA_W-1:0] lsu_data;

   logic              issue_valid;
   logic [REG_W-1:0]  issue_reg;

   logic [REG_W-1:0]  a_reg;
   logic [REG_W-1:0]  b_reg;
   logic              a_pending;
   logic              b_pending;

   logic              stall_req;
   logic              write_back_en;
   logic [REG_W-1:0]  write_back_reg;
   logic [DATA_W-1:0] write_back;

   modport master (
      output alu_valid, alu_reg, alu_data,
      output lsu_valid, lsu_reg, lsu_data,
      input  lsu_ready,
      output issue_valid, issue_reg,
      output a_reg, b_reg,
      input  a_pending, b_pending,
      input  stall_req, write_back_en, write_back_reg, write_back
   );

   modport slave (
      input  alu_valid, alu_reg, alu_data,
      input  lsu_valid, lsu_reg, lsu_data,
      output lsu_ready,
      input  issue_valid, issue_reg,
      input  a_reg, b_reg,
      output a_pending, b_pending,
      output stall_req, write_back_en, write_back_reg, write_back
   );
endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Small synchronous FIFO of write-back entries. Pointers carry one extra
// wrap bit so full/empty are distinguished without a separate count.
module wb_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  wb_entry_t din,
   output wb_entry_t dout,
   output logic      full,
   output logic      empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   wb_entry_t   mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; the pointers define which slots are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/writeback_arbiter.sv
// Owns the register-file write port: ALU results win each cycle, buffered LSU
// results fill idle slots, and a pending map tracks outstanding long-latency writes.
module writeback_arbiter
   import mips_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   writeback_arbiter_if.slave bus
);
   localparam logic [3:0] STARVE_TC = 4'(STARVE_MAX - 1);

   wb_entry_t         lsu_in;
   wb_entry_t         head;
   wb_entry_t         sel;
   logic              sel_valid;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;
   logic [3:0]          age_q;
   logic                stall_q;
   logic                wb_en_q;
   logic [REG_W-1:0]    wb_reg_q;
   logic [DATA_W-1:0]   wb_data_q;

   assign lsu_in        = '{dst_reg: bus.lsu_reg, data: bus.lsu_data};
   assign push          = bus.lsu_valid && !full;
   assign bus.lsu_ready = !full;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (lsu_in),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      sel_valid = 1'b0;
      pop       = 1'b0;
      sel       = head;
      if (bus.alu_valid) begin
         sel_valid = 1'b1;
         sel       = '{dst_reg: bus.alu_reg, data: bus.alu_data};
      end else if (!empty) begin
         sel_valid = 1'b1;
         pop       = 1'b1;
      end
   end

   // Idle slots keep the last reg/data; only the strobe drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en_q   <= 1'b0;
         wb_reg_q  <= '0;
         wb_data_q <= '0;
      end else begin
         wb_en_q <= sel_valid && (sel.dst_reg != ZERO_REG);
         if (sel_valid) begin
            wb_reg_q  <= sel.dst_reg;
            wb_data_q <= sel.data;
         end
      end
   end

   // A new issue to the register retiring this edge must stay pending.
   always_comb begin
      pending_d = pending_q;
      if (pop) pending_d[head.dst_reg] = 1'b0;
      if (bus.issue_valid && (bus.issue_reg != ZERO_REG)) pending_d[bus.issue_reg] = 1'b1;
      pending_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending_q <= '0;
      else     pending_q <= pending_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         age_q   <= '0;
         stall_q <= 1'b0;
      end else begin
         if (empty || pop)      age_q <= '0;
         else if (age_q != 4'hF) age_q <= age_q + 4'd1;
         stall_q <= !empty && (age_q >= STARVE_TC);
      end
   end

   assign bus.a_pending      = pending_q[bus.a_reg];
   assign bus.b_pending      = pending_q[bus.b_reg];
   assign bus.stall_req      = stall_q;
   assign bus.write_back_en  = wb_en_q;
   assign bus.write_back_reg = wb_reg_q;
   assign bus.write_back     = wb_data_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scenario bench for writeback_arbiter: expected writes go into a queue as
// stimulus is driven and a negedge monitor retires them against the write port.
module tb_writeback_arbiter;
   import mips_pkg::*;

   localparam int STARVE_MAX = 4;

   logic clk;
   logic rst;
   int   n_total = 0;
   int   n_pass  = 0;
   wb_entry_t sb_q[$];

   writeback_arbiter_if bus ();

   writeback_arbiter #(.DEPTH(2), .STARVE_MAX(STARVE_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: run did not end, time %0t", $time);
      $fatal(1);
   end

   always @(negedge clk) begin
      if (bus.write_back_en === 1'b1) begin
         wb_entry_t exp;
         n_total++;
         if (sb_q.size() == 0) begin
            $display("FAIL sb_unexpected: got write reg=%0d data=%h, want no write",
                     bus.write_back_reg, bus.write_back);
         end else begin
            exp = sb_q.pop_front();
            if (bus.write_back_reg !== exp.dst_reg || bus.write_back !== exp.data)
               $display("FAIL sb_write: got reg=%0d data=%h, want reg=%0d data=%h",
                        bus.write_back_reg, bus.write_back, exp.dst_reg, exp.data);
            else n_pass++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_check(input string name);
      @(negedge clk);
      #1;
      n_total++;
      if (sb_q.size() != 0) $display("FAIL %s_drain: got %0d outstanding writes, want 0", name, sb_q.size());
      else n_pass++;
   endtask

   task automatic drive_alu(input logic [4:0] r, input logic [31:0] d);
      bus.alu_valid = 1'b1;
      bus.alu_reg   = r;
      bus.alu_data  = d;
      if (r != ZERO_REG) sb_q.push_back('{dst_reg: r, data: d});
   endtask

   task automatic test_reset();
      #11;
      rst = 1'b0;
      bus.a_reg = 5'd7;
      bus.b_reg = 5'd31;
      #1;
      n_total++; if (bus.write_back_en !== 1'b0) $display("FAIL rst_en: got %0b want 0", bus.write_back_en); else n_pass++;
      n_total++; if (bus.write_back_reg !== 5'd0) $display("FAIL rst_reg: got %0d want 0", bus.write_back_reg); else n_pass++;
      n_total++; if (bus.write_back !== 32'd0) $display("FAIL rst_data: got %h want 0", bus.write_back); else n_pass++;
      n_total++; if (bus.stall_req !== 1'b0) $display("FAIL rst_stall: got %0b want 0", bus.stall_req); else n_pass++;
      n_total++; if (bus.lsu_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", bus.lsu_ready); else n_pass++;
      n_total++; if (bus.a_pending !== 1'b0 || bus.b_pending !== 1'b0)
         $display("FAIL rst_pending: got a=%0b b=%0b want 0 0", bus.a_pending, bus.b_pending); else n_pass++;
   endtask

   task automatic test_alu();
      logic [31:0] last_d;
      drive_alu(5'd3, 32'h0000_00AA);
      step();
      n_total++; if (bus.write_back_en !== 1'b1 || bus.write_back_reg !== 5'd3 || bus.write_back !== 32'hAA)
         $display("FAIL alu_basic: got en=%0b reg=%0d data=%h want 1 3 000000aa",
                  bus.write_back_en, bus.write_back_reg, bus.write_back); else n_pass++;
      drive_alu(5'd0, 32'h5555_5555);
      step();
      n_total++; if (bus.write_back_en !== 1'b0) $display("FAIL alu_reg0: got en=%0b want 0", bus.write_back_en); else n_pass++;
      last_d = '0;
      for (int i = 1; i <= 4; i++) begin
         last_d = $urandom;
         drive_alu(5'(i), last_d);
         step();
      end
      bus.alu_valid = 1'b0;
      step();
      n_total++; if (bus.write_back_en !== 1'b0 || bus.write_back_reg !== 5'd4 || bus.write_back !== last_d)
         $display("FAIL alu_hold: got en=%0b reg=%0d data=%h want 0 4 %h",
                  bus.write_back_en, bus.write_back_reg, bus.write_back, last_d); else n_pass++;
      drain_check("alu");
   endtask

   task automatic test_lsu();
      bus.a_reg       = 5'd7;
      bus.issue_valid = 1'b1;
      bus.issue_reg   = 5'd7;
      step();
      bus.issue_valid = 1'b0;
      n_total++; if (bus.a_pending !== 1'b1) $display("FAIL lsu_pend_set: got %0b want 1", bus.a_pending); else n_pass++;
      n_total++; if (bus.lsu_ready !== 1'b1) $display("FAIL lsu_ready: got %0b want 1", bus.lsu_ready); else n_pass++;
      bus.lsu_valid = 1'b1;
      bus.lsu_reg   = 5'd7;
      bus.lsu_data  = 32'h1234;
      sb_q.push_back('{dst_reg: 5'd7, data: 32'h1234});
      step();
      bus.lsu_valid = 1'b0;
      n_total++; if (bus.write_back_en !== 1'b0 || bus.a_pending !== 1'b1)
         $display("FAIL lsu_latency: got en=%0b pend=%0b want 0 1", bus.write_back_en, bus.a_pending); else n_pass++;
      step();
      n_total++; if (bus.write_back_en !== 1'b1 || bus.write_back_reg !== 5'd7 || bus.write_back !== 32'h1234)
         $display("FAIL lsu_write: got en=%0b reg=%0d data=%h want 1 7 00001234",
                  bus.write_back_en, bus.write_back_reg, bus.write_back); else n_pass++;
      n_total++; if (bus.a_pending !== 1'b0) $display("FAIL lsu_pend_clr: got %0b want 0", bus.a_pending); else n_pass++;
      drain_check("lsu");
   endtask

   task automatic test_priority_full();
      bus.lsu_valid = 1'b1;
      bus.lsu_reg = 5'd5; bus.lsu_data = 32'd1;
      drive_alu(5'd10, 32'd100);
      step();
      bus.lsu_reg = 5'd6; bus.lsu_data = 32'd2;
      drive_alu(5'd11, 32'd101);
      step();
      n_total++; if (bus.lsu_ready !== 1'b0) $display("FAIL prio_full: got ready=%0b want 0", bus.lsu_ready); else n_pass++;
      bus.lsu_reg = 5'd8; bus.lsu_data = 32'd3;
      drive_alu(5'd12, 32'd102);
      step();
      n_total++; if (bus.lsu_ready !== 1'b0) $display("FAIL prio_hold: got ready=%0b want 0", bus.lsu_ready); else n_pass++;
      bus.lsu_valid = 1'b0;
      bus.alu_valid = 1'b0;
      sb_q.push_back('{dst_reg: 5'd5, data: 32'd1});
      sb_q.push_back('{dst_reg: 5'd6, data: 32'd2});
      step();
      n_total++; if (bus.write_back_en !== 1'b1 || bus.write_back_reg !== 5'd5 || bus.write_back !== 32'd1)
         $display("FAIL prio_first: got en=%0b reg=%0d data=%h want 1 5 1",
                  bus.write_back_en, bus.write_back_reg, bus.write_back); else n_pass++;
      n_total++; if (bus.lsu_ready !== 1'b1) $display("FAIL prio_ready: got %0b want 1", bus.lsu_ready); else n_pass++;
      step();
      n_total++; if (bus.write_back_en !== 1'b1 || bus.write_back_reg !== 5'd6 || bus.write_back !== 32'd2)
         $display("FAIL prio_second: got en=%0b reg=%0d data=%h want 1 6 2",
                  bus.write_back_en, bus.write_back_reg, bus.write_back); else n_pass++;
      step();
      n_total++; if (bus.write_back_en !== 1'b0) $display("FAIL prio_idle: got en=%0b want 0", bus.write_back_en); else n_pass++;
      drain_check("prio");
   endtask

   task automatic test_starvation();
      bus.lsu_valid = 1'b1;
      bus.lsu_reg = 5'd9; bus.lsu_data = 32'hBEEF;
      drive_alu(5'd11, 32'd500);
      step();
      bus.lsu_valid = 1'b0;
      n_total++; if (bus.stall_req !== 1'b0) $display("FAIL starve_init: got %0b want 0", bus.stall_req); else n_pass++;
      for (int k = 1; k <= STARVE_MAX; k++) begin
         drive_alu(5'd11, 32'(500 + k));
         step();
         n_total++; if (bus.stall_req !== (k == STARVE_MAX))
            $display("FAIL starve_cycle%0d: got stall=%0b want %0b", k, bus.stall_req, (k == STARVE_MAX)); else n_pass++;
      end
      bus.alu_valid = 1'b0;
      sb_q.push_back('{dst_reg: 5'd9, data: 32'hBEEF});
      step();
      n_total++; if (bus.write_back_en !== 1'b1 || bus.write_back_reg !== 5'd9 || bus.write_back !== 32'hBEEF)
         $display("FAIL starve_write: got en=%0b reg=%0d data=%h want 1 9 0000beef",
                  bus.write_back_en, bus.write_back_reg, bus.write_back); else n_pass++;
      step();
      n_total++; if (bus.stall_req !== 1'b0) $display("FAIL starve_release: got %0b want 0", bus.stall_req); else n_pass++;
      drain_check("starve");
   endtask

   task automatic test_reset_mid();
      bus.a_reg       = 5'd4;
      bus.issue_valid = 1'b1;
      bus.issue_reg   = 5'd4;
      bus.lsu_valid   = 1'b1;
      bus.lsu_reg = 5'd4; bus.lsu_data = 32'hAAAA;
      drive_alu(5'd20, 32'd200);
      step();
      bus.issue_valid = 1'b0;
      bus.lsu_reg = 5'd12; bus.lsu_data = 32'hBBBB;
      drive_alu(5'd21, 32'd201);
      step();
      bus.alu_valid = 1'b0;
      bus.lsu_valid = 1'b0;
      n_total++; if (bus.a_pending !== 1'b1 || bus.lsu_ready !== 1'b0)
         $display("FAIL mid_setup: got pend=%0b ready=%0b want 1 0", bus.a_pending, bus.lsu_ready); else n_pass++;
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_total++; if (bus.lsu_ready !== 1'b1 || bus.a_pending !== 1'b0 || bus.write_back_en !== 1'b0)
         $display("FAIL mid_reset: got ready=%0b pend=%0b en=%0b want 1 0 0",
                  bus.lsu_ready, bus.a_pending, bus.write_back_en); else n_pass++;
      step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_total++; if (bus.write_back_en !== 1'b0 || bus.a_pending !== 1'b0)
            $display("FAIL mid_after%0d: got en=%0b pend=%0b want 0 0", k, bus.write_back_en, bus.a_pending); else n_pass++;
      end
      drain_check("mid");
   endtask

   initial begin
      rst             = 1'b1;
      bus.alu_valid   = 1'b0;
      bus.alu_reg     = '0;
      bus.alu_data    = '0;
      bus.lsu_valid   = 1'b0;
      bus.lsu_reg     = '0;
      bus.lsu_data    = '0;
      bus.issue_valid = 1'b0;
      bus.issue_reg   = '0;
      bus.a_reg       = '0;
      bus.b_reg       = '0;
      test_reset();
      step();
      test_alu();
      test_lsu();
      test_priority_full();
      test_starvation();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
